// File: rtl/sprite_vram_loader.sv
// Writes one ENTITYSIZE x ENTITYSIZE sprite into a single-port VRAM, in raster order,
// from either a pixel stream (with optional colour-key skip) or a constant fill value.
//
// state | meaning
// IDLE  | waiting for i_start; latches mode, fill value and key enable
// LOAD  | accepting stream beats, one registered VRAM write per accepted beat
// FILL  | one registered VRAM write of the latched fill value per cycle
// DONE  | last write on the bus, o_done pulse; returns to IDLE next edge
module sprite_vram_loader #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ENTITYSIZE = 32,
  parameter logic [DATA_WIDTH-1:0] KEY        = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [DATA_WIDTH-1:0] i_fill,
  input  logic                  i_key_en,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_write,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int                    SHIFT    = $clog2(ENTITYSIZE);
  localparam logic [ADDR_WIDTH-1:0] EDGE_MAX = ADDR_WIDTH'(ENTITYSIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_x;
  logic [ADDR_WIDTH-1:0] r_y;
  logic [DATA_WIDTH-1:0] r_fill;
  logic                  r_key_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_done;

  logic                  w_load_beat;
  logic                  w_step;
  logic                  w_last;
  logic                  w_skip;
  logic [ADDR_WIDTH-1:0] w_pix_addr;
  logic [DATA_WIDTH-1:0] w_pix_data;

  assign w_load_beat = (r_state == S_LOAD) && i_valid;
  assign w_step      = w_load_beat || (r_state == S_FILL);
  assign w_last      = (r_x == EDGE_MAX) && (r_y == EDGE_MAX);
  // x < ENTITYSIZE and ENTITYSIZE is a power of two, so OR-ing equals y*ENTITYSIZE + x
  assign w_pix_addr  = (r_y << SHIFT) | r_x;
  assign w_pix_data  = (r_state == S_FILL) ? r_fill : i_data;
  assign w_skip      = (r_state == S_LOAD) && r_key_en && (i_data == KEY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_fill   <= '0;
      r_key_en <= 1'b0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_write <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_fill   <= i_fill;
            r_key_en <= i_key_en;
            r_x      <= '0;
            r_y      <= '0;
            r_state  <= i_mode ? S_FILL : S_LOAD;
          end
        end
        S_LOAD, S_FILL: begin
          if (w_step) begin
            r_addr  <= w_pix_addr;
            r_wdata <= w_pix_data;
            r_write <= !w_skip;
            if (r_x == EDGE_MAX) begin
              r_x <= '0;
              r_y <= r_y + ADDR_WIDTH'(1);
            end else begin
              r_x <= r_x + ADDR_WIDTH'(1);
            end
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready = (r_state == S_LOAD);
  assign o_busy  = (r_state != S_IDLE);
  assign o_addr  = r_addr;
  assign o_write = r_write;
  assign o_wdata = r_wdata;
  assign o_done  = r_done;

endmodule

// File: tb/tb_sprite_vram_loader.sv
// Randomized bench for sprite_vram_loader (4x4 sprite): a pixel-index model predicts every
// output each cycle, and captured VRAM contents are pinned with hand-computed images.
module tb_sprite_vram_loader;

  localparam int ES = 4;
  localparam int N  = ES * ES;
  localparam int P_IDLE = 0, P_LOAD = 1, P_FILL = 2, P_DONE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0, i_mode = 1'b0, i_key_en = 1'b0, i_valid = 1'b0;
  logic [7:0] i_fill = 8'h00, i_data = 8'h00;
  logic       o_ready, o_write, o_busy, o_done;
  logic [7:0] o_addr, o_wdata;

  int checks = 0;
  int failures = 0;

  sprite_vram_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .ENTITYSIZE(ES), .KEY(8'h00)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_fill(i_fill),
    .i_key_en(i_key_en), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .o_addr(o_addr), .o_write(o_write), .o_wdata(o_wdata), .o_busy(o_busy), .o_done(o_done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation is a sequence of N pixels indexed 0..N-1 (= address)
  int         m_phase = P_IDLE;
  int         m_n = 0;
  int         m_op_writes = 0;
  bit         m_fill_mode, m_key;
  logic [7:0] m_fill;
  logic [7:0] e_addr = 8'h00, e_wdata = 8'h00;
  logic       e_write = 1'b0, e_done = 1'b0;
  bit   [7:0] m_mem [256];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE; e_addr = 8'h00; e_wdata = 8'h00; e_write = 1'b0; e_done = 1'b0;
    end else begin
      e_write = 1'b0;
      e_done  = 1'b0;
      if (m_phase == P_DONE) begin
        m_phase = P_IDLE;
      end else if (m_phase == P_IDLE) begin
        if (i_start) begin
          m_fill_mode = i_mode; m_fill = i_fill; m_key = i_key_en;
          m_n = 0; m_op_writes = 0;
          m_phase = i_mode ? P_FILL : P_LOAD;
        end
      end else if (m_phase == P_FILL || i_valid) begin
        e_addr  = 8'(m_n);
        e_wdata = m_fill_mode ? m_fill : i_data;
        e_write = m_fill_mode || !(m_key && i_data == 8'h00);
        if (e_write) begin
          m_mem[m_n] = e_wdata;
          m_op_writes++;
        end
        m_n++;
        if (m_n == N) begin
          m_phase = P_DONE;
          e_done  = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare plus capture of what the DUT actually wrote
  bit   [7:0] vram [256];
  int         cyc = 0, busy_cyc = 0, done_cyc = 0, op_writes = 0;
  logic [7:0] done_addr = 8'h00, first_wr_addr = 8'hFF;
  bit         prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      chk("ready", 32'(o_ready), 32'(m_phase == P_LOAD));
      chk("busy",  32'(o_busy),  32'(m_phase != P_IDLE));
      chk("write", 32'(o_write), 32'(e_write));
      chk("done",  32'(o_done),  32'(e_done));
      chk("addr",  32'(o_addr),  32'(e_addr));
      chk("wdata", 32'(o_wdata), 32'(e_wdata));
      if (o_write) begin
        vram[o_addr] = o_wdata;
        if (op_writes == 0) first_wr_addr = o_addr;
        op_writes++;
      end
      if (o_done) begin
        done_addr = o_addr;
        done_cyc  = cyc;
      end
      if (o_busy && !prev_busy) busy_cyc = cyc;
      prev_busy = o_busy;
    end
  end

  function automatic logic [7:0] beat_data(input int kind, input int b);
    if (kind == 0) return 8'(16 + b);
    if (kind == 1) return (b % 2 == 1) ? 8'h07 : 8'h00;
    return ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
  endfunction

  task automatic do_start(input bit mode, input logic [7:0] fill, input bit key);
    i_start = 1'b1; i_mode = mode; i_fill = fill; i_key_en = key;
    op_writes = 0;
    first_wr_addr = 8'hFF;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // vpat: 0 continuous, 1 toggling, 2 random valid
  task automatic run_stream(input int n, input int vpat, input int kind, input bit pulse);
    int b, c;
    bit v, rdy;
    logic [7:0] d;
    b = 0; c = 0;
    d = beat_data(kind, 0);
    while (b < n && c < 400) begin
      rdy = o_ready;
      v = (vpat == 0) ? 1'b1 : (vpat == 1) ? (c % 2 == 0) : ($urandom_range(0, 1) == 1);
      i_valid = v; i_data = d; i_start = pulse && (c == 7);
      @(negedge clk);
      if (v && rdy) begin
        b++;
        d = beat_data(kind, b);
      end
      c++;
    end
    i_valid = 1'b0; i_start = 1'b0;
    chk("stream_beats_in_budget", 32'(b), 32'(n));
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (o_busy && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("op_finished_in_budget", 32'(o_busy), 32'd0);
  endtask

  task automatic cmp_image();
    for (int a = 0; a < N; a++) chk("vram_vs_model", 32'(vram[a]), 32'(m_mem[a]));
    chk("op_write_count", 32'(op_writes), 32'(m_op_writes));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 0); chk("rst_busy", 32'(o_busy), 0);
    chk("rst_write", 32'(o_write), 0); chk("rst_done", 32'(o_done), 0);
    chk("rst_addr", 32'(o_addr), 0);   chk("rst_wdata", 32'(o_wdata), 0);
    rst = 1'b0;
    @(negedge clk);

    // continuous stream 0x10+i
    do_start(1'b0, 8'h00, 1'b0);
    run_stream(N, 0, 0, 1'b0);
    wait_done();
    chk("t1_writes", 32'(op_writes), 32'd16);
    for (int a = 0; a < N; a++) chk("t1_image", 32'(vram[a]), 32'(8'h10 + a));
    chk("t1_done_addr", 32'(done_addr), 32'd15);
    chk("t1_busy_to_done", 32'(done_cyc - busy_cyc), 32'd16);

    // valid toggling, random pixels
    do_start(1'b0, 8'h00, 1'b0);
    run_stream(N, 1, 2, 1'b0);
    wait_done();
    chk("t2_writes", 32'(op_writes), 32'd16);
    cmp_image();

    // fill 0xA5
    do_start(1'b1, 8'hA5, 1'b0);
    wait_done();
    chk("t3_writes", 32'(op_writes), 32'd16);
    chk("t3_done_addr", 32'(done_addr), 32'd15);
    for (int a = 0; a < N; a++) chk("t3_image", 32'(vram[a]), 32'h A5);

    // colour key over the fill: 0x00 beats are transparent
    do_start(1'b0, 8'h00, 1'b1);
    run_stream(N, 0, 1, 1'b0);
    wait_done();
    chk("t4_writes", 32'(op_writes), 32'd8);
    chk("t4_done_addr", 32'(done_addr), 32'd15);
    for (int a = 0; a < N; a++) chk("t4_image", 32'(vram[a]), (a % 2 == 1) ? 32'h07 : 32'hA5);

    // start pulsed mid-load, then beats offered while idle
    do_start(1'b0, 8'h00, 1'b0);
    run_stream(N, 2, 2, 1'b1);
    wait_done();
    i_valid = 1'b1; i_data = 8'h5A;
    repeat (6) @(negedge clk);
    i_valid = 1'b0;
    chk("t5_writes", 32'(op_writes), 32'd16);
    chk("t5_still_idle", 32'(o_busy), 32'd0);
    cmp_image();

    // reset after five accepted beats
    do_start(1'b0, 8'h00, 1'b0);
    run_stream(5, 0, 0, 1'b0);
    chk("t6_pre_rst_write", 32'(o_write), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(o_ready), 0); chk("t6_rst_busy", 32'(o_busy), 0);
    chk("t6_rst_write", 32'(o_write), 0); chk("t6_rst_done", 32'(o_done), 0);
    chk("t6_rst_addr", 32'(o_addr), 0);   chk("t6_rst_wdata", 32'(o_wdata), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(1'b0, 8'h00, 1'b0);
    run_stream(N, 0, 0, 1'b0);
    wait_done();
    chk("t6_first_addr", 32'(first_wr_addr), 32'd0);
    chk("t6_writes", 32'(op_writes), 32'd16);
    cmp_image();

    // random operations
    repeat (8) begin
      bit md, ky;
      md = ($urandom_range(0, 1) == 1);
      ky = ($urandom_range(0, 1) == 1);
      do_start(md, 8'($urandom), ky);
      if (!md) run_stream(N, 2, 2, ($urandom_range(0, 1) == 1));
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      cmp_image();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
